axi4_read_arbiter: RTL and testbench

AXI4_READ_ARBITER -- requirements
Module: axi4_read_arbiter

---
 rtl/axi4_globals_pkg.sv | 11 +
 rtl/axi4_outstanding_counter.sv | 27 ++
 rtl/axi4_read_arbiter.sv | 131 +++++++++++++
 tb/tb_axi4_read_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_globals_pkg.sv
// Shared types and defaults for the AXI4 read arbiter slice.
package axi4_globals_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_SEND = 1'b1} arb_state_e;

  localparam int ARB_NUM_REQ          = 2;
  localparam int AXI_ADDRESS_WIDTH    = 32;
  localparam int AXI_DATA_WIDTH       = 64;
  localparam int OUTSTANDING_CNT_W    = 5;

endpackage

// File: rtl/axi4_outstanding_counter.sv
// Per-requester outstanding-burst counter; decrements saturate at zero and flag underflow.
module axi4_outstanding_counter
  import axi4_globals_pkg::*;
#(
  parameter int CNT_W = OUTSTANDING_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  logic dec_eff;

  // A decrement at zero is ignored but reported, so an increment in the same cycle still counts.
  assign underflow = dec && (cnt == '0);
  assign dec_eff   = dec && (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset)                 cnt <= '0;
    else if (inc && !dec_eff)  cnt <= cnt + 1'b1;
    else if (!inc && dec_eff)  cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/axi4_read_arbiter.sv
// Two-requester AXI4 read arbiter: round-robin AR mux with registered output, ID-routed R path.
module axi4_read_arbiter
  import axi4_globals_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = AXI_ADDRESS_WIDTH,
  parameter int DATA_WIDTH      = AXI_DATA_WIDTH,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic [1:0]                             s_arvalid,
  output logic [1:0]                             s_arready,
  input  logic [1:0][ADDRESS_WIDTH-1:0]          s_araddr,
  input  logic [1:0][ID_WIDTH-1:0]               s_arid,
  input  logic [1:0][7:0]                        s_arlen,
  input  logic [1:0][2:0]                        s_arsize,
  input  logic [1:0][1:0]                        s_arburst,
  output logic                                   m_arvalid,
  input  logic                                   m_arready,
  output logic [ADDRESS_WIDTH-1:0]               m_araddr,
  output logic [ID_WIDTH:0]                      m_arid,
  output logic [7:0]                             m_arlen,
  output logic [2:0]                             m_arsize,
  output logic [1:0]                             m_arburst,
  input  logic                                   m_rvalid,
  output logic                                   m_rready,
  input  logic [ID_WIDTH:0]                      m_rid,
  input  logic [DATA_WIDTH-1:0]                  m_rdata,
  input  logic [1:0]                             m_rresp,
  input  logic                                   m_rlast,
  output logic [1:0]                             s_rvalid,
  input  logic [1:0]                             s_rready,
  output logic [ID_WIDTH-1:0]                    s_rid,
  output logic [DATA_WIDTH-1:0]                  s_rdata,
  output logic [1:0]                             s_rresp,
  output logic                                   s_rlast,
  output logic [1:0][OUTSTANDING_CNT_W-1:0]      outstanding_cnt,
  output logic                                   err_unexpected_r
);

  arb_state_e                   state, state_nxt;
  logic                         ptr;
  logic                         winner;
  logic [ARB_NUM_REQ-1:0]       eligible;
  logic                         ar_hs;
  logic                         r_idx;
  logic                         r_done;
  logic [ARB_NUM_REQ-1:0]       underflow;

  // Eligibility and round-robin winner selection
  always_comb begin
    for (int i = 0; i < ARB_NUM_REQ; i++)
      eligible[i] = s_arvalid[i] &&
                    ({{(32-OUTSTANDING_CNT_W){1'b0}}, outstanding_cnt[i]} < 32'(MAX_OUTSTANDING));
    if (&eligible) winner = ptr;
    else           winner = eligible[1];
  end

  assign ar_hs = (state == ARB_IDLE) && (|eligible);

  always_ff @(posedge aclk) begin
    if (areset) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (ar_hs)     state_nxt = ARB_SEND;
      ARB_SEND: if (m_arready) state_nxt = ARB_IDLE;
      default:                 state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_arready = '0;
    m_arvalid = (state == ARB_SEND);
    if (ar_hs) s_arready[winner] = 1'b1;
  end

  // AR output register: loaded only on a grant, so fields stay stable under backpressure
  always_ff @(posedge aclk) begin
    if (areset) begin
      ptr       <= 1'b0;
      m_araddr  <= '0;
      m_arid    <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
    end else if (ar_hs) begin
      ptr       <= ~winner;
      m_araddr  <= s_araddr[winner];
      m_arid    <= {winner, s_arid[winner]};
      m_arlen   <= s_arlen[winner];
      m_arsize  <= s_arsize[winner];
      m_arburst <= s_arburst[winner];
    end
  end

  // R path is purely combinational, steered by the requester bit of the ID
  assign r_idx    = m_rid[ID_WIDTH];
  assign m_rready = s_rready[r_idx];
  assign s_rid    = m_rid[ID_WIDTH-1:0];
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;
  assign r_done   = m_rvalid && m_rready && m_rlast;

  always_comb begin
    s_rvalid        = '0;
    s_rvalid[r_idx] = m_rvalid;
  end

  for (genvar i = 0; i < ARB_NUM_REQ; i++) begin : g_cnt
    axi4_outstanding_counter #(.CNT_W(OUTSTANDING_CNT_W)) u_cnt (
      .clk       (aclk),
      .reset     (areset),
      .inc       (ar_hs && (winner == 1'(i))),
      .dec       (r_done && (r_idx == 1'(i))),
      .cnt       (outstanding_cnt[i]),
      .underflow (underflow[i])
    );
  end

  always_ff @(posedge aclk) begin
    if (areset) err_unexpected_r <= 1'b0;
    else        err_unexpected_r <= |underflow;
  end

endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Directed bench: R-routing vector table plus hand-written AR arbitration sequences.
module tb_axi4_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic                 aclk = 1'b0;
  logic                 areset;
  logic [1:0]           s_arvalid, s_arready;
  logic [1:0][AW-1:0]   s_araddr;
  logic [1:0][IW-1:0]   s_arid;
  logic [1:0][7:0]      s_arlen;
  logic [1:0][2:0]      s_arsize;
  logic [1:0][1:0]      s_arburst;
  logic                 m_arvalid, m_arready;
  logic [AW-1:0]        m_araddr;
  logic [IW:0]          m_arid;
  logic [7:0]           m_arlen;
  logic [2:0]           m_arsize;
  logic [1:0]           m_arburst;
  logic                 m_rvalid, m_rready;
  logic [IW:0]          m_rid;
  logic [DW-1:0]        m_rdata;
  logic [1:0]           m_rresp;
  logic                 m_rlast;
  logic [1:0]           s_rvalid, s_rready;
  logic [IW-1:0]        s_rid;
  logic [DW-1:0]        s_rdata;
  logic [1:0]           s_rresp;
  logic                 s_rlast;
  logic [1:0][4:0]      outstanding_cnt;
  logic                 err_unexpected_r;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi4_read_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(16)) dut (
    .aclk(aclk), .areset(areset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .outstanding_cnt(outstanding_cnt), .err_unexpected_r(err_unexpected_r)
  );

  typedef struct {
    logic          rvalid;
    logic [IW:0]   rid;
    logic          rlast;
    logic [1:0]    rready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic [1:0]    e_svalid;
    logic          e_mready;
    logic [IW-1:0] e_sid;
    logic [4:0]    e_c0;
    logic [4:0]    e_c1;
    logic          e_err;
  } rvec_t;

  rvec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // rvalid rid last rready data resp | svalid mready sid c0 c1 err  (cnt0=3, cnt1=3 on entry)
    tbl[0] = '{1'b1, 5'h15, 1'b1, 2'b10, 64'h1111, 2'd0, 2'b10, 1'b1, 4'h5, 5'd3, 5'd2, 1'b0};
    tbl[1] = '{1'b1, 5'h02, 1'b0, 2'b01, 64'h2222, 2'd1, 2'b01, 1'b1, 4'h2, 5'd3, 5'd2, 1'b0};
    tbl[2] = '{1'b1, 5'h07, 1'b1, 2'b10, 64'h3333, 2'd2, 2'b01, 1'b0, 4'h7, 5'd3, 5'd2, 1'b0};
    tbl[3] = '{1'b0, 5'h1F, 1'b1, 2'b11, 64'h4444, 2'd3, 2'b00, 1'b1, 4'hF, 5'd3, 5'd2, 1'b0};
    tbl[4] = '{1'b1, 5'h00, 1'b1, 2'b01, 64'h5555, 2'd0, 2'b01, 1'b1, 4'h0, 5'd2, 5'd2, 1'b0};
    tbl[5] = '{1'b1, 5'h1A, 1'b1, 2'b11, 64'h6666, 2'd1, 2'b10, 1'b1, 4'hA, 5'd2, 5'd1, 1'b0};
    tbl[6] = '{1'b1, 5'h11, 1'b1, 2'b10, 64'h7777, 2'd2, 2'b10, 1'b1, 4'h1, 5'd2, 5'd0, 1'b0};
    tbl[7] = '{1'b1, 5'h15, 1'b1, 2'b10, 64'h8888, 2'd3, 2'b10, 1'b1, 4'h5, 5'd2, 5'd0, 1'b1};
    tbl[8] = '{1'b0, 5'h00, 1'b0, 2'b00, 64'h9999, 2'd0, 2'b01, 1'b0, 4'h0, 5'd2, 5'd0, 1'b0};

    areset = 1'b1; s_arvalid = '0; m_arready = 1'b0;
    s_araddr = '0; s_arid = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; s_rready = '0;
    step(); step();
    areset = 1'b0;
    settle();
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_m_araddr", 64'(m_araddr), 64'd0);
    chk("rst_cnt", 64'(outstanding_cnt), 64'd0);
    chk("rst_err", 64'(err_unexpected_r), 64'd0);

    // Single request on req0
    s_araddr[0] = 32'h1000; s_arid[0] = 4'd3; s_arlen[0] = 8'd7; s_arsize[0] = 3'd3; s_arburst[0] = 2'd1;
    s_araddr[1] = 32'h2000; s_arid[1] = 4'd5; s_arlen[1] = 8'd3; s_arsize[1] = 3'd2; s_arburst[1] = 2'd2;
    s_arvalid = 2'b01;
    settle();
    chk("single_arready", 64'(s_arready), 64'b01);
    step();
    s_arvalid = 2'b00;
    settle();
    chk("single_m_arvalid", 64'(m_arvalid), 64'd1);
    chk("single_m_arid", 64'(m_arid), 64'h03);
    chk("single_m_araddr", 64'(m_araddr), 64'h1000);
    chk("single_m_arlen", 64'(m_arlen), 64'd7);
    chk("single_cnt0", 64'(outstanding_cnt[0]), 64'd1);
    chk("single_send_ready", 64'(s_arready), 64'b00);
    m_arready = 1'b1;
    step();
    chk("single_done", 64'(m_arvalid), 64'd0);

    // Backpressure with req1 holding the AR channel
    m_arready = 1'b0;
    s_arvalid = 2'b10;
    step();
    s_arvalid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_m_arvalid", 64'(m_arvalid), 64'd1);
      chk("bp_m_araddr", 64'(m_araddr), 64'h2000);
      chk("bp_m_arid", 64'(m_arid), 64'h15);
      chk("bp_fields", 64'({m_arlen, m_arsize, m_arburst}), 64'({8'd3, 3'd2, 2'd2}));
      chk("bp_s_arready", 64'(s_arready), 64'b00);
    end
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    step();
    chk("bp_cnt1", 64'(outstanding_cnt[1]), 64'd1);

    // Contention: grants alternate starting at req0
    s_arvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rr_arready", 64'(s_arready), (k % 2 == 0) ? 64'b01 : 64'b10);
      step();
      chk("rr_m_arid_msb", 64'(m_arid[IW]), 64'(k % 2));
      step();
    end
    s_arvalid = 2'b00;
    settle();
    chk("rr_cnts", 64'(outstanding_cnt), 64'({5'd3, 5'd3}));

    // R routing table
    for (int k = 0; k < 9; k++) begin
      m_rvalid = tbl[k].rvalid; m_rid = tbl[k].rid; m_rlast = tbl[k].rlast;
      s_rready = tbl[k].rready; m_rdata = tbl[k].rdata; m_rresp = tbl[k].rresp;
      settle();
      chk($sformatf("r%0d_s_rvalid", k), 64'(s_rvalid), 64'(tbl[k].e_svalid & {2{tbl[k].rvalid}}));
      chk($sformatf("r%0d_m_rready", k), 64'(m_rready), 64'(tbl[k].e_mready));
      chk($sformatf("r%0d_s_rid", k), 64'(s_rid), 64'(tbl[k].e_sid));
      chk($sformatf("r%0d_bcast", k), {s_rdata[60:0], s_rresp, s_rlast},
          {tbl[k].rdata[60:0], tbl[k].rresp, tbl[k].rlast});
      step();
      chk($sformatf("r%0d_cnt0", k), 64'(outstanding_cnt[0]), 64'(tbl[k].e_c0));
      chk($sformatf("r%0d_cnt1", k), 64'(outstanding_cnt[1]), 64'(tbl[k].e_c1));
      chk($sformatf("r%0d_err", k), 64'(err_unexpected_r), 64'(tbl[k].e_err));
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;

    // Limit: fill req0 to 16 outstanding
    for (int k = 0; k < 14; k++) begin
      s_arvalid = 2'b01;
      step();
      s_arvalid = 2'b00;
      step();
    end
    chk("lim_cnt0", 64'(outstanding_cnt[0]), 64'd16);
    s_arvalid = 2'b11;
    settle();
    chk("lim_req1_only", 64'(s_arready), 64'b10);
    step();
    step();
    s_arvalid = 2'b01;
    settle();
    chk("lim_blocked", 64'(s_arready), 64'b00);
    m_rvalid = 1'b1; m_rid = 5'h00; m_rlast = 1'b1; s_rready = 2'b01;
    settle();
    chk("lim_blocked_rbeat", 64'(s_arready), 64'b00);
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;
    settle();
    chk("lim_cnt0_dec", 64'(outstanding_cnt[0]), 64'd15);
    chk("lim_unblocked", 64'(s_arready), 64'b01);
    step();
    s_arvalid = 2'b00;
    chk("lim_cnt0_refill", 64'(outstanding_cnt[0]), 64'd16);
    step();

    // Reset while an AR is pending
    m_arready = 1'b0;
    s_arvalid = 2'b10;
    step();
    chk("rs_pending", 64'(m_arvalid), 64'd1);
    areset = 1'b1;
    s_arvalid = 2'b00;
    step();
    areset = 1'b0;
    chk("rs_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rs_m_arid", 64'(m_arid), 64'd0);
    chk("rs_cnts", 64'(outstanding_cnt), 64'd0);
    s_arvalid = 2'b11;
    settle();
    chk("rs_prio0", 64'(s_arready), 64'b01);
    step();
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    step();

    // Simultaneous inc and dec on req1
    s_arvalid = 2'b10;
    step();
    s_arvalid = 2'b00;
    step();
    chk("sim_cnt1_pre", 64'(outstanding_cnt[1]), 64'd1);
    s_arvalid = 2'b10;
    m_rvalid = 1'b1; m_rid = 5'h10; m_rlast = 1'b1; s_rready = 2'b10;
    settle();
    chk("sim_grant", 64'(s_arready), 64'b10);
    step();
    s_arvalid = 2'b00; m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;
    chk("sim_cnt1", 64'(outstanding_cnt[1]), 64'd1);
    chk("sim_err", 64'(err_unexpected_r), 64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
